ram_preload_ctrl: RTL and testbench
===================================

Name: ram_preload_ctrl

Overview:
- Hardware replacement for the bench-side RAM preload loop. Accepts a byte stream (file reader or UART front end) and packs bytes big-endian into byte, halfword or word units.
- Writes each unit into the datapath RAM through its MAR/MDR/MOV/MOC interface at consecutive addresses, with a MOC timeout.
- Sits between the stream source and the RAM port; the datapath is held off while Busy=1.

Parameters:
- ADDR_W, 9, RAM byte-address width.
- TIMEOUT, 16, max cycles waiting on a MOC edge before error (>=2).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- nReset  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; accepted only in IDLE, DONE or ERROR.
- Start_Addr  in  ADDR_W  first byte address; low bits masked to unit alignment.
- Pack  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word); sampled at Start.
- In_Data  in  8  stream byte.
- In_Valid  in  1  byte present.
- In_Last  in  1  qualifies the final byte of the stream (valid only with In_Valid).
- In_Ready  out  1  byte accepted when In_Valid & In_Ready.
- MAR  out  ADDR_W  RAM address.
- MDR  out  32  RAM write data, right-justified.
- Type  out  2  RAM access size, equal to the latched Pack.
- RW  out  1  0 = write; constant 0 while Busy, 1 otherwise.
- MOV  out  1  memory operation valid.
- MOC  in  1  memory operation complete.
- Busy  out  1  high in every state other than IDLE, DONE and ERROR.
- Done  out  1  high in DONE.
- Error  out  1  high in ERROR.
- Wrapped  out  1  sticky; set if the address rolled past 2^ADDR_W-1.
- Unit_Count  out  ADDR_W+1  number of units written since Start.

Behaviour:
- Reset (async, any state, including mid-write) forces:
  - State IDLE.
  - MOV=0, RW=1, In_Ready=0, MAR=0, MDR=0, Type=0.
  - Done=0, Error=0, Wrapped=0, Unit_Count=0.
  - Pack register=0, byte index=0.
- Units: N = 1, 2 or 4 bytes. Mask = N-1 applied to Start_Addr.
- State COLLECT:
  - In_Ready=1.
  - Accepted bytes shift in big-endian: the first byte is the MSB of the unit.
  - After byte N, or after In_Last, go to WRITE in the next cycle; In_Ready drops in that cycle.
  - A partial unit on In_Last is left-justified and zero-padded to N bytes (e.g. word, 2 bytes AB,CD → MDR=32'hABCD0000).
- State WRITE:
  - MAR, MDR and Type are stable. MOV=1 from the first WRITE cycle.
  - Wait for MOC=1, then go to RELEASE.
- State RELEASE:
  - MOV=0. Wait for MOC=0.
  - Then MAR += N modulo 2^ADDR_W and Unit_Count += 1.
  - If the address wrapped to 0, set Wrapped and continue.
  - Go to DONE if this unit carried In_Last, else COLLECT.
- MOC timeout:
  - In WRITE or RELEASE, a counter resets on state entry.
  - If the awaited MOC level is not seen within TIMEOUT cycles: MOV=0, go to ERROR. No address increment, no count.
- DONE and ERROR hold until Start or reset. RW returns to 1 there.
- Start in IDLE, DONE or ERROR:
  - Latch Pack and the aligned Start_Addr.
  - Clear Done, Error, Wrapped and Unit_Count; go to COLLECT.
- Start while Busy is ignored.
- In_Last with In_Valid=0 is ignored.
- Simultaneous In_Valid and Start in IDLE: the byte is not accepted, since In_Ready=0 in that cycle.
- Minimum per-unit latency with MOC answering in 1 cycle: N accept cycles + 1 WRITE + 1 RELEASE.

Test Plan:
- Byte mode, Start_Addr=0, stream 8'h11,22,33 (Last on 33), MOC echoes MOV after 1 cycle → three writes at MAR 0,1,2; MDR 32'h11, 32'h22, 32'h33; Type=00; Unit_Count=3; Done=1.
- Word mode, Start_Addr=9'h007 (masked to 9'h004), bytes DE,AD,BE,EF,01 (Last on 01) → MDR=32'hDEADBEEF at MAR 4, then 32'h01000000 at MAR 8; Done=1.
- Halfword mode with In_Valid toggling every other cycle → no byte lost or duplicated; MDR 16-bit values correct; In_Ready=0 in WRITE and RELEASE.
- MOC held 0 for TIMEOUT cycles in WRITE → MOV falls, Error=1, MAR unchanged, Unit_Count unchanged; a following Start clears Error.
- Byte mode from Start_Addr=9'h1FF, two bytes → writes at 9'h1FF then 9'h000; Wrapped=1.
- nReset asserted while MOV=1 → MOV=0, RW=1, Busy=0 immediately (asynchronous); all outputs at reset values.

Source files
------------

// File: rtl/ram_preload_ctrl.sv
// rtl/ram_preload_ctrl.sv - packs a byte stream big-endian into byte/halfword/word units
// and writes them to the datapath RAM over the MAR/MDR/MOV/MOC handshake.
module ram_preload_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Start_Addr,
  input  logic [1:0]        Pack,
  input  logic [7:0]        In_Data,
  input  logic              In_Valid,
  input  logic              In_Last,
  output logic              In_Ready,
  output logic [ADDR_W-1:0] MAR,
  output logic [31:0]       MDR,
  output logic [1:0]        Type,
  output logic              RW,
  output logic              MOV,
  input  logic              MOC,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              Wrapped,
  output logic [ADDR_W:0]   Unit_Count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        pack_q;
  logic [ADDR_W-1:0] mar_q;
  logic [31:0]       mdr_q;
  logic [1:0]        byte_idx_q;
  logic              last_q;
  logic [TW-1:0]     timer_q;
  logic              wrapped_q;
  logic [ADDR_W:0]   count_q;

  logic              accept;
  logic              can_start;
  logic              moc_expired;
  logic [1:0]        last_idx;
  logic [2:0]        n_bytes;
  logic [1:0]        slot;
  logic [31:0]       mdr_base;
  logic [ADDR_W-1:0] align_mask;
  logic [ADDR_W:0]   next_addr;

  // Reserved pack code 11 behaves as a word.
  always_comb begin
    unique case (pack_q)
      2'b00:   begin n_bytes = 3'd1; last_idx = 2'd0; end
      2'b01:   begin n_bytes = 3'd2; last_idx = 2'd1; end
      default: begin n_bytes = 3'd4; last_idx = 2'd3; end
    endcase
  end

  always_comb begin
    unique case (Pack)
      2'b00:   align_mask = '1;
      2'b01:   align_mask = {{(ADDR_W-1){1'b1}}, 1'b0};
      default: align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};
    endcase
  end

  assign accept      = In_Valid & In_Ready;
  assign moc_expired = (timer_q == TW'(TIMEOUT - 1));
  assign next_addr   = {1'b0, mar_q} + (ADDR_W+1)'(n_bytes);
  // First byte of a unit lands in the top slot and clears the rest, so a short unit is zero-padded.
  assign slot        = last_idx - byte_idx_q;
  assign mdr_base    = (byte_idx_q == 2'd0) ? 32'h0 : mdr_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    In_Ready  = 1'b0;
    MOV       = 1'b0;
    can_start = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        can_start = 1'b1;
        if (Start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        In_Ready = 1'b1;
        if (accept && (In_Last || byte_idx_q == last_idx)) state_d = S_WRITE;
      end
      S_WRITE: begin
        MOV = 1'b1;
        if (MOC)              state_d = S_RELEASE;
        else if (moc_expired) state_d = S_ERROR;
      end
      S_RELEASE: begin
        if (!MOC)             state_d = last_q ? S_DONE : S_COLLECT;
        else if (moc_expired) state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pack_q     <= 2'b00;
      mar_q      <= '0;
      mdr_q      <= 32'h0;
      byte_idx_q <= 2'd0;
      last_q     <= 1'b0;
      timer_q    <= '0;
      wrapped_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      // Timer restarts whenever a wait state is entered.
      if ((state_q == S_WRITE || state_q == S_RELEASE) && state_d == state_q)
        timer_q <= timer_q + 1'b1;
      else
        timer_q <= '0;

      if (can_start && Start) begin
        pack_q     <= Pack;
        mar_q      <= Start_Addr & align_mask;
        byte_idx_q <= 2'd0;
        last_q     <= 1'b0;
        wrapped_q  <= 1'b0;
        count_q    <= '0;
      end

      if (state_q == S_COLLECT && accept) begin
        mdr_q <= mdr_base | (32'(In_Data) << {slot, 3'b000});
        if (In_Last) last_q <= 1'b1;
        byte_idx_q <= (In_Last || byte_idx_q == last_idx) ? 2'd0 : byte_idx_q + 2'd1;
      end

      if (state_q == S_RELEASE && !MOC) begin
        mar_q   <= next_addr[ADDR_W-1:0];
        count_q <= count_q + 1'b1;
        if (next_addr[ADDR_W]) wrapped_q <= 1'b1;
      end
    end
  end

  assign Busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign RW         = ~Busy;
  assign Done       = (state_q == S_DONE);
  assign Error      = (state_q == S_ERROR);
  assign MAR        = mar_q;
  assign MDR        = mdr_q;
  assign Type       = pack_q;
  assign Wrapped    = wrapped_q;
  assign Unit_Count = count_q;

endmodule

// File: tb/tb_ram_preload_ctrl.sv
// tb/tb_ram_preload_ctrl.sv - randomized stream/RAM-responder bench for ram_preload_ctrl
// with a unit-list reference model.
module tb_ram_preload_ctrl;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;
  localparam int RAM_SZ  = 1 << ADDR_W;

  logic              Clk = 1'b0;
  logic              nReset;
  logic              Start;
  logic [ADDR_W-1:0] Start_Addr;
  logic [1:0]        Pack;
  logic [7:0]        In_Data;
  logic              In_Valid;
  logic              In_Last;
  logic              In_Ready;
  logic [ADDR_W-1:0] MAR;
  logic [31:0]       MDR;
  logic [1:0]        Type;
  logic              RW;
  logic              MOV;
  logic              MOC;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic              Wrapped;
  logic [ADDR_W:0]   Unit_Count;

  always #5 Clk = ~Clk;

  ram_preload_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Start_Addr(Start_Addr), .Pack(Pack),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(In_Ready),
    .MAR(MAR), .MDR(MDR), .Type(Type), .RW(RW), .MOV(MOV), .MOC(MOC), .Busy(Busy),
    .Done(Done), .Error(Error), .Wrapped(Wrapped), .Unit_Count(Unit_Count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]        stream[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic [1:0]        got_type[$];
  int                mov_cycles;
  bit                timed_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    nReset = 1'b0;
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mov"}, 32'(MOV), 32'd0);
    check({tag, "_rw"}, 32'(RW), 32'd1);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_in_ready"}, 32'(In_Ready), 32'd0);
    check({tag, "_mar"}, 32'(MAR), 32'd0);
    check({tag, "_mdr"}, MDR, 32'd0);
    check({tag, "_type"}, 32'(Type), 32'd0);
    check({tag, "_flags"}, {29'd0, Done, Error, Wrapped}, 32'd0);
    check({tag, "_count"}, 32'(Unit_Count), 32'd0);
  endtask

  // vmode: 0 always valid, 1 every other cycle, 2 random. RAM answers after 0..2 cycle delays.
  task automatic drive(input logic [1:0] pack, input logic [ADDR_W-1:0] saddr,
                       input int vmode, input bit moc_on, input int budget);
    int idx = 0;
    int dly = 0;
    int cyc = 0;
    bit v;
    got_addr.delete(); got_data.delete(); got_type.delete();
    mov_cycles = 0;
    timed_out  = 1'b1;
    @(negedge Clk);
    Start = 1'b1; Start_Addr = saddr; Pack = pack; MOC = 1'b0;
    In_Valid = 1'b1; In_Data = stream[0]; In_Last = (stream.size() == 1);
    while (cyc < budget) begin
      @(negedge Clk);
      Start = 1'b0;
      cyc++;
      if (Done || Error) begin
        timed_out = 1'b0;
        break;
      end
      if (MOV) mov_cycles++;
      if (moc_on) begin
        if (MOV && !MOC) begin
          if (dly == 0) begin
            got_addr.push_back(MAR); got_data.push_back(MDR); got_type.push_back(Type);
            check("in_ready_during_write", 32'(In_Ready), 32'd0);
            MOC = 1'b1;
            dly = $urandom_range(0, 2);
          end else dly--;
        end else if (!MOV && MOC) begin
          if (dly == 0) begin
            MOC = 1'b0;
            dly = $urandom_range(0, 2);
          end else dly--;
        end
      end
      if (idx < stream.size()) begin
        v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
        In_Valid = v;
        In_Data  = v ? stream[idx] : 8'($urandom);
        In_Last  = v ? (idx == stream.size() - 1) : bit'($urandom_range(0, 1));
        if (v && In_Ready) idx++;
      end else begin
        In_Valid = 1'b0;
        In_Last  = bit'($urandom_range(0, 1));
      end
    end
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic check_run(input logic [1:0] pack, input int saddr);
    int n, base, units;
    logic [31:0] exp;
    n     = (pack == 2'b00) ? 1 : (pack == 2'b01) ? 2 : 4;
    base  = saddr - (saddr % n);
    units = (stream.size() + n - 1) / n;
    check("run_budget", 32'(timed_out), 32'd0);
    check("n_writes", 32'(got_addr.size()), 32'(units));
    for (int u = 0; u < units && u < got_addr.size(); u++) begin
      exp = 32'h0;
      for (int i = 0; i < n; i++)
        exp = (exp << 8) | ((u * n + i < stream.size()) ? 32'(stream[u * n + i]) : 32'h0);
      check("mar", 32'(got_addr[u]), 32'((base + u * n) % RAM_SZ));
      check("mdr", got_data[u], exp);
      check("type", 32'(got_type[u]), 32'(pack));
    end
    check("unit_count", 32'(Unit_Count), 32'(units));
    check("wrapped", 32'(Wrapped), 32'((base + units * n) >= RAM_SZ));
    check("done", 32'(Done), 32'd1);
    check("error", 32'(Error), 32'd0);
    check("busy_end", 32'(Busy), 32'd0);
    check("rw_end", 32'(RW), 32'd1);
  endtask

  task automatic run_case(input logic [1:0] pack, input int saddr, input int vmode);
    drive(pack, ADDR_W'(saddr), vmode, 1'b1, 400);
    check_run(pack, saddr);
  endtask

  initial begin
    logic [1:0] p;
    int sa, nb;
    nReset = 1'b0; Start = 1'b0; Start_Addr = '0; Pack = 2'b00;
    In_Data = 8'h0; In_Valid = 1'b0; In_Last = 1'b0; MOC = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge Clk);
    nReset = 1'b1;

    stream = '{8'h11, 8'h22, 8'h33};
    run_case(2'b00, 0, 0);
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    run_case(2'b10, 9'h007, 0);
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hF0};
    run_case(2'b01, 9'h003, 1);
    stream = '{8'hA5, 8'h5A};
    run_case(2'b00, 9'h1FF, 0);
    stream = '{8'hC3, 8'h3C, 8'h77};
    run_case(2'b11, 9'h1FE, 2);

    for (int r = 0; r < 20; r++) begin
      p  = 2'($urandom_range(0, 3));
      sa = $urandom_range(0, RAM_SZ - 1);
      nb = $urandom_range(1, 12);
      stream.delete();
      for (int i = 0; i < nb; i++) stream.push_back(8'($urandom));
      run_case(p, sa, 2);
    end

    // RAM never answers: the write must be abandoned after TIMEOUT cycles of MOV.
    stream = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive(2'b10, 9'h00D, 0, 1'b0, 100);
    check("timeout_budget", 32'(timed_out), 32'd0);
    check("timeout_error", 32'(Error), 32'd1);
    check("timeout_mov", 32'(MOV), 32'd0);
    check("timeout_mov_cycles", 32'(mov_cycles), 32'(TIMEOUT));
    check("timeout_mar", 32'(MAR), 32'h00C);
    check("timeout_count", 32'(Unit_Count), 32'd0);
    check("timeout_done", 32'(Done), 32'd0);
    Start = 1'b1; Start_Addr = 9'h020; Pack = 2'b00;
    @(negedge Clk);
    Start = 1'b0;
    check("restart_error_cleared", 32'(Error), 32'd0);
    check("restart_busy", 32'(Busy), 32'd1);
    check("restart_mar", 32'(MAR), 32'h020);
    pulse_reset();

    // Asynchronous reset in the middle of a write.
    @(negedge Clk);
    Start = 1'b1; Start_Addr = 9'h005; Pack = 2'b01;
    In_Valid = 1'b1; In_Data = 8'h77; In_Last = 1'b1; MOC = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      In_Valid = 1'b0; In_Last = 1'b0;
      if (MOV) break;
    end
    check("mov_before_reset", 32'(MOV), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge Clk);
    nReset = 1'b1;

    stream = '{8'h99};
    run_case(2'b00, 9'h1FF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
